gba_sio_normal_ctrl: RTL and testbench

Sequencer for the GBA link port in SIO Normal mode (8- or 32-bit shift transfers). It drives the GBA link signal group (si/so/sck/sd, each with a to_gba value and an is_to_gba direction enable) and is wired to the top-level link pins via the link interface's pin-connect helper. The core side has a one-word request/response handshake. Master clocking is always present; slave (external clock) operation is optional.

---
 rtl/gba_sio_pkg.sv | 30 +++
 rtl/gba_sio_sync.sv | 42 ++++
 rtl/gba_sio_normal_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_gba_sio_normal_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_sio_pkg.sv
// ============================================================================
// Module   : gba_sio_pkg
// Purpose  : Shared states, constants and helpers for the GBA SIO Normal-mode
//            link sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gba_sio_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOW    = 3'd1,
        HIGH   = 3'd2,
        S_WAIT = 3'd3,
        DONE   = 3'd4
    } sio_state_t;

    localparam int   BITS8   = 8;
    localparam int   BITS32  = 32;
    localparam logic SO_IDLE = 1'b1;

    // 8-bit results are delivered zero-extended.
    function automatic logic [31:0] rx_fmt(input logic is_32, input logic [31:0] word);
        return is_32 ? word : {24'h0, word[7:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/gba_sio_sync.sv
// ============================================================================
// Module   : gba_sio_sync
// Purpose  : Two-flop synchroniser for an asynchronous link pin, with
//            rise/fall detection on the synchronised level.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gba_sio_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/gba_sio_normal_ctrl.sv
// ============================================================================
// Module   : gba_sio_normal_ctrl
// Purpose  : GBA link-port SIO Normal-mode (8/32-bit) transfer sequencer.
//            Slave (external clock) operation is built when GBA_SIO_SLAVE_EN
//            is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gba_sio_normal_ctrl
    import gba_sio_pkg::*;
#(
    parameter int HALF_PERIOD = 145,
    parameter int TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic        start_is_32,
    input  logic [31:0] start_data,
    input  logic        slave_mode,
    output logic        rx_valid,
    output logic [31:0] rx_data,
    output logic        busy,
    output logic        err,
    input  logic        si_from_gba,
    input  logic        sck_from_gba,
    output logic        si_to_gba,
    output logic        si_is_to_gba,
    output logic        sd_to_gba,
    output logic        sd_is_to_gba,
    output logic        so_to_gba,
    output logic        so_is_to_gba,
    output logic        sck_to_gba,
    output logic        sck_is_to_gba
);

    localparam int              HP_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);

    sio_state_t        r_state;
    logic [31:0]       r_shift;
    logic [4:0]        r_bit_cnt;
    logic [HP_W-1:0]   r_hp_cnt;
    logic              r_is_32;
    logic              r_slave;
    logic              r_rx_valid;
    logic [31:0]       r_rx_data;
    logic              r_busy;
    logic              r_err;
    logic              r_sck;
    logic              r_so;
    logic              r_sck_oe;

    logic              w_si;
    logic              w_si_rise;
    logic              w_si_fall;
    logic              w_sck_level;
    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_slave_req;
    logic [31:0]       w_load;
    logic [31:0]       w_shift_in;
    logic              w_unused_edges;

    gba_sio_sync #(.RESET_VAL(1'b1)) u_sync_sck (
        .clk     (clk),
        .reset   (reset),
        .i_async (sck_from_gba),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    gba_sio_sync #(.RESET_VAL(1'b1)) u_sync_si (
        .clk     (clk),
        .reset   (reset),
        .i_async (si_from_gba),
        .o_level (w_si),
        .o_rise  (w_si_rise),
        .o_fall  (w_si_fall)
    );

    assign w_unused_edges = ^{w_sck_level, w_si_rise, w_si_fall};

`ifdef GBA_SIO_SLAVE_EN
    localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] r_to_cnt;
    assign w_slave_req = slave_mode;
`else
    logic w_unused_slave;
    assign w_slave_req    = 1'b0;
    assign w_unused_slave = ^{slave_mode, w_sck_rise, w_sck_fall, (TIMEOUT > 0)};
`endif

    // 8-bit words are left-aligned so the MSB is always bit 31.
    assign w_load     = start_is_32 ? start_data : {start_data[7:0], 24'h0};
    assign w_shift_in = {r_shift[30:0], w_si};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_hp_cnt   <= '0;
            r_is_32    <= 1'b0;
            r_slave    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_sck      <= 1'b1;
            r_so       <= SO_IDLE;
            r_sck_oe   <= 1'b0;
`ifdef GBA_SIO_SLAVE_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_sck_oe   <= ~r_slave;
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_shift   <= w_load;
                        r_bit_cnt <= start_is_32 ? 5'(BITS32 - 1) : 5'(BITS8 - 1);
                        r_is_32   <= start_is_32;
                        r_busy    <= 1'b1;
                        r_so      <= w_load[31];
                        r_hp_cnt  <= '0;
                        r_slave   <= w_slave_req;
                        r_sck_oe  <= ~w_slave_req;
                        if (w_slave_req) begin
                            r_state  <= S_WAIT;
`ifdef GBA_SIO_SLAVE_EN
                            r_to_cnt <= '0;
`endif
                        end else begin
                            r_state <= LOW;
                            r_sck   <= 1'b0;
                        end
                    end
                end
                LOW: begin
                    if (r_hp_cnt == HP_LAST) begin
                        r_hp_cnt <= '0;
                        r_sck    <= 1'b1;
                        r_state  <= HIGH;
                    end else begin
                        r_hp_cnt <= r_hp_cnt + HP_W'(1);
                    end
                end
                HIGH: begin
                    if (r_hp_cnt == HP_LAST) begin
                        r_hp_cnt <= '0;
                        r_shift  <= w_shift_in;
                        if (r_bit_cnt == 5'd0) begin
                            r_state    <= DONE;
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= rx_fmt(r_is_32, w_shift_in);
                            r_so       <= SO_IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                            r_sck     <= 1'b0;
                            r_so      <= w_shift_in[31];
                            r_state   <= LOW;
                        end
                    end else begin
                        r_hp_cnt <= r_hp_cnt + HP_W'(1);
                    end
                end
`ifdef GBA_SIO_SLAVE_EN
                S_WAIT: begin
                    if (w_sck_rise) begin
                        r_to_cnt <= '0;
                        r_shift  <= w_shift_in;
                        if (r_bit_cnt == 5'd0) begin
                            r_state    <= DONE;
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= rx_fmt(r_is_32, w_shift_in);
                            r_so       <= SO_IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                        end
                    end else if (w_sck_fall) begin
                        r_to_cnt <= '0;
                        r_so     <= r_shift[31];
                    end else if (r_to_cnt == TO_LAST) begin
                        // Partner stopped clocking: hand back whatever arrived.
                        r_state    <= DONE;
                        r_rx_valid <= 1'b1;
                        r_err      <= 1'b1;
                        r_rx_data  <= rx_fmt(r_is_32, r_shift);
                        r_so       <= SO_IDLE;
                        r_busy     <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
`endif
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_ready   = (r_state == IDLE);
    assign rx_valid      = r_rx_valid;
    assign rx_data       = r_rx_data;
    assign busy          = r_busy;
    assign err           = r_err;
    assign si_to_gba     = 1'b0;
    assign si_is_to_gba  = 1'b0;
    assign sd_to_gba     = 1'b0;
    assign sd_is_to_gba  = 1'b0;
    assign so_to_gba     = r_so;
    assign so_is_to_gba  = 1'b1;
    assign sck_to_gba    = r_sck;
    assign sck_is_to_gba = r_sck_oe;

endmodule

`default_nettype wire

// File: tb/tb_gba_sio_normal_ctrl.sv
// ============================================================================
// Module   : tb_gba_sio_normal_ctrl
// Purpose  : Self-checking bench for gba_sio_normal_ctrl (master transfers,
//            handshake corners, reset abort; slave cases with GBA_SIO_SLAVE_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gba_sio_normal_ctrl;

    localparam int HP = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic        start_is_32;
    logic [31:0] start_data;
    logic        slave_mode;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        busy;
    logic        err;
    logic        si_from_gba;
    logic        sck_from_gba;
    logic        si_to_gba, si_is_to_gba, sd_to_gba, sd_is_to_gba;
    logic        so_to_gba, so_is_to_gba, sck_to_gba, sck_is_to_gba;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    gba_sio_normal_ctrl #(.HALF_PERIOD(HP), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .start_is_32   (start_is_32),
        .start_data    (start_data),
        .slave_mode    (slave_mode),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .busy          (busy),
        .err           (err),
        .si_from_gba   (si_from_gba),
        .sck_from_gba  (sck_from_gba),
        .si_to_gba     (si_to_gba),
        .si_is_to_gba  (si_is_to_gba),
        .sd_to_gba     (sd_to_gba),
        .sd_is_to_gba  (sd_is_to_gba),
        .so_to_gba     (so_to_gba),
        .so_is_to_gba  (so_is_to_gba),
        .sck_to_gba    (sck_to_gba),
        .sck_is_to_gba (sck_is_to_gba)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: a link partner sees the N low bits MSB first.
    function automatic logic [31:0] model_word(input logic is32, input logic [31:0] v);
        return is32 ? v : {24'h0, v[7:0]};
    endfunction

    function automatic int model_latency(input logic is32);
        return 1 + 2 * HP * (is32 ? 32 : 8);
    endfunction

    logic [31:0] g_rx, g_so;
    int          g_lat, g_nfall, g_bad;
    logic        g_ok, g_so_done, g_err_done;

    task automatic wait_ready();
        int b = 0;
        @(negedge clk);
        while (!start_ready && b < 2000) begin
            @(negedge clk);
            b++;
        end
    endtask

    // Acts as the link partner: on each sck fall, records SO and presents the next SI bit.
    task automatic run_master(input logic is32, input logic [31:0] data, input logic [31:0] partner);
        int   t0;
        int   n;
        logic prev_sck;
        n = is32 ? 32 : 8;
        g_ok = 0; g_rx = '0; g_lat = -1; g_so = '0; g_nfall = 0; g_bad = 0;
        g_so_done = 1'bx; g_err_done = 1'bx;
        wait_ready();
        start_valid = 1'b1; start_is_32 = is32; start_data = data; slave_mode = 1'b0;
        t0 = cyc;
        prev_sck = sck_to_gba;
        @(negedge clk);
        start_valid = 1'b0;
        for (int k = 0; k < 2 * HP * n + 40; k++) begin
            if (prev_sck && !sck_to_gba) begin
                g_so = {g_so[30:0], so_to_gba};
                if (g_nfall < n) si_from_gba = partner[n - 1 - g_nfall];
                g_nfall++;
            end
            prev_sck = sck_to_gba;
            if (busy && start_ready) g_bad++;
            if (rx_valid) begin
                g_ok = 1; g_rx = rx_data; g_lat = cyc - t0;
                g_so_done = so_to_gba; g_err_done = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_master(input string tag, input logic is32, input logic [31:0] data,
                                input logic [31:0] exp_rx, input int exp_lat);
        chk({tag, " rx_valid seen"}, 32'(g_ok), 32'd1);
        chk({tag, " rx_data"}, g_rx, exp_rx);
        chk({tag, " latency"}, g_lat, exp_lat);
        chk({tag, " so bits"}, g_so, model_word(is32, data));
        chk({tag, " sck falls"}, g_nfall, is32 ? 32 : 8);
        chk({tag, " so idle at done"}, 32'(g_so_done), 32'd1);
        chk({tag, " err at done"}, 32'(g_err_done), 32'd0);
        chk({tag, " ready while busy"}, g_bad, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        is32;
        logic [31:0] data;
        logic [31:0] partner;
        logic [31:0] exp_rx;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] d, p;
        logic        b32, seen;
        int          bad, nf, nrx, t_edge, delta;
        logic        prev;

        vecs[0] = '{"m8 A5 loopback",  1'b0, 32'h0000_00A5, 32'h0000_00A5, 32'h0000_00A5, 65};
        vecs[1] = '{"m32 si high",     1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 257};
        vecs[2] = '{"m8 si low",       1'b0, 32'h0000_003C, 32'h0000_0000, 32'h0000_0000, 65};
        vecs[3] = '{"m32 pattern",     1'b1, 32'h8000_0001, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 257};
        vecs[4] = '{"m8 upper ignored",1'b0, 32'hDEAD_BE5A, 32'hFFFF_FF81, 32'h0000_0081, 65};

        reset = 1'b1; start_valid = 1'b0; start_is_32 = 1'b0; start_data = '0;
        slave_mode = 1'b0; si_from_gba = 1'b1; sck_from_gba = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset sck_to_gba", 32'(sck_to_gba), 32'd1);
        chk("reset so_to_gba", 32'(so_to_gba), 32'd1);
        chk("reset sck_is_to_gba", 32'(sck_is_to_gba), 32'd0);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rx_data", rx_data, 32'd0);
        chk("constant pins", {28'd0, si_to_gba, si_is_to_gba, sd_to_gba, sd_is_to_gba}, 32'd0);
        chk("so_is_to_gba", 32'(so_is_to_gba), 32'd1);

        reset = 1'b0;
        @(negedge clk);
        chk("sck_is_to_gba after reset", 32'(sck_is_to_gba), 32'd1);
        chk("start_ready idle", 32'(start_ready), 32'd1);

        foreach (vecs[i]) begin
            run_master(vecs[i].is32, vecs[i].data, vecs[i].partner);
            check_master(vecs[i].name, vecs[i].is32, vecs[i].data, vecs[i].exp_rx, vecs[i].exp_lat);
        end

        for (int i = 0; i < 6; i++) begin
            b32 = 1'($urandom_range(0, 1));
            d = $urandom;
            p = $urandom;
            run_master(b32, d, p);
            check_master("random", b32, d, model_word(b32, p), model_latency(b32));
        end

        // Back-to-back: request held high across a whole transfer.
        wait_ready();
        start_valid = 1'b1; start_is_32 = 1'b0; start_data = 32'h0000_0069; slave_mode = 1'b0;
        bad = 0; seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy && start_ready) bad++;
            if (rx_valid) begin seen = 1'b1; break; end
        end
        chk("b2b first rx_valid seen", 32'(seen), 32'd1);
        chk("b2b ready while busy", bad, 32'd0);
        chk("b2b ready in DONE", 32'(start_ready), 32'd0);
        @(negedge clk);
        chk("b2b ready after DONE", 32'(start_ready), 32'd1);
        @(negedge clk);
        start_valid = 1'b0;
        chk("b2b second accepted", 32'(busy), 32'd1);
        chk("b2b ready second busy", 32'(start_ready), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rx_valid) begin seen = 1'b1; break; end
        end
        chk("b2b second rx_valid seen", 32'(seen), 32'd1);

        // Reset in the middle of bit 3.
        wait_ready();
        start_valid = 1'b1; start_is_32 = 1'b0; start_data = 32'h0000_00F0;
        prev = 1'b1; nf = 0;
        @(negedge clk);
        start_valid = 1'b0;
        for (int k = 0; k < 200 && nf < 4; k++) begin
            if (prev && !sck_to_gba) nf++;
            prev = sck_to_gba;
            if (nf < 4) @(negedge clk);
        end
        chk("abort reached bit 3", nf, 32'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort sck_to_gba", 32'(sck_to_gba), 32'd1);
        chk("abort so_to_gba", 32'(so_to_gba), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        nrx = 0;
        for (int k = 0; k < 150; k++) begin
            if (rx_valid) nrx++;
            @(negedge clk);
        end
        chk("abort no rx_valid", nrx, 32'd0);
        chk("abort sck_is_to_gba", 32'(sck_is_to_gba), 32'd1);
        chk("abort start_ready", 32'(start_ready), 32'd1);

`ifdef GBA_SIO_SLAVE_EN
        // Slave 8-bit with a 20-cycle external half period.
        wait_ready();
        start_valid = 1'b1; slave_mode = 1'b1; start_is_32 = 1'b0; start_data = 32'h0000_005A;
        @(negedge clk);
        start_valid = 1'b0; slave_mode = 1'b0;
        chk("slave sck_is_to_gba", 32'(sck_is_to_gba), 32'd0);
        chk("slave so msb", 32'(so_to_gba), 32'd0);
        p = 32'h0000_003C; g_so = '0; bad = 0; seen = 1'b0; g_rx = '0; g_err_done = 1'b1;
        for (int b = 0; b < 8; b++) begin
            sck_from_gba = 1'b0;
            si_from_gba = p[7 - b];
            repeat (20) begin @(negedge clk); if (sck_is_to_gba) bad++; end
            g_so = {g_so[30:0], so_to_gba};
            sck_from_gba = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (sck_is_to_gba) bad++;
                if (rx_valid) begin seen = 1'b1; g_rx = rx_data; g_err_done = err; end
            end
        end
        chk("slave rx_valid seen", 32'(seen), 32'd1);
        chk("slave rx_data", g_rx, 32'h0000_003C);
        chk("slave err", 32'(g_err_done), 32'd0);
        chk("slave so bits", g_so, 32'h0000_005A);
        chk("slave sck_is_to_gba held 0", bad, 32'd0);

        // Slave timeout: partner stops after 3 bits (1,0,1).
        wait_ready();
        start_valid = 1'b1; slave_mode = 1'b1; start_is_32 = 1'b0; start_data = 32'h0000_00FF;
        @(negedge clk);
        start_valid = 1'b0; slave_mode = 1'b0;
        p = 32'h0000_0005;
        t_edge = 0; seen = 1'b0;
        for (int b = 0; b < 3; b++) begin
            sck_from_gba = 1'b0;
            si_from_gba = p[2 - b];
            repeat (20) @(negedge clk);
            sck_from_gba = 1'b1;
            t_edge = cyc;
            repeat (20) begin @(negedge clk); if (rx_valid) seen = 1'b1; end
        end
        chk("timeout no early rx_valid", 32'(seen), 32'd0);
        delta = -1;
        for (int k = 0; k < 400; k++) begin
            if (rx_valid) begin
                delta = cyc - t_edge; g_rx = rx_data; g_err_done = err;
                break;
            end
            @(negedge clk);
        end
        chk("timeout latency window", 32'(delta >= TO && delta <= TO + 4), 32'd1);
        chk("timeout err", 32'(g_err_done), 32'd1);
        chk("timeout partial bits", {29'd0, g_rx[2:0]}, 32'd5);
        @(negedge clk);
        chk("timeout err one cycle", 32'(err), 32'd0);
        chk("timeout back in idle", 32'(start_ready), 32'd1);
        chk("oe stays low after slave", 32'(sck_is_to_gba), 32'd0);

        run_master(1'b0, 32'h0000_0033, 32'h0000_00C3);
        check_master("master after slave", 1'b0, 32'h0000_0033, 32'h0000_00C3, 65);
        chk("oe restored by master", 32'(sck_is_to_gba), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
